// File: rtl/cla_nibble_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_adder
//
// Purpose:
//   Sequential WIDTH-bit adder that processes one 4-bit nibble per clock
//   through a 4-bit carry look-ahead stage. Per-nibble generate/propagate
//   terms feed the look-ahead carries. Those carries form the nibble sum, and
//   the nibble carry-out is registered as the carry-in for the next nibble.
//
// Parameters:
//   WIDTH      operand width, a multiple of 4 and >= 4 (N = WIDTH/4 nibbles)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/cin valid
//   in_ready   block can accept (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   cin        carry-in to nibble 0
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow
//
// Optional feature macro:
//   CLA_OVF_EN  when defined, ovf is registered as C3^C2 of the top nibble.
//               When undefined, ovf is tied to 0 and has no register.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   valid must not depend on ready. On the input side, the operands are
//   sampled on the accept edge only. On the output side, out_valid and
//   sum/cout/ovf stay stable from the rise of out_valid until the transfer.
//
// Debug:
//   The FSM state is the internal signal state_q (type state_t).
// -----------------------------------------------------------------------------
module cla_nibble_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;   // carry into nibble k (cin when k == 0)
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             accept;
   logic             release_res;
   logic             last_nib;
   logic [KW+1:0]    base;
   logic [3:0]       g, p, nib_sum;
   logic [3:0]       c;         // look-ahead carries C3..C0

   assign in_ready    = (state_q == IDLE) && !rst;
   assign out_valid   = (state_q == DONE);
   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;
   assign last_nib    = (k_q == K_LAST);
   assign base        = {k_q, 2'b00};

   // One nibble of look-ahead logic; no ripple across the full width.
   always_comb begin
      g = a_q[base +: 4] & b_q[base +: 4];
      p = a_q[base +: 4] ^ b_q[base +: 4];
      c[0] = g[0] | (p[0] & carry_q);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry_q);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry_q);
      nib_sum = p ^ {c[2:0], carry_q};
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_nib) state_d = DONE;
         DONE:    if (release_res) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  k_q     <= '0;
               end
            end
            RUN: begin
               sum_q[base +: 4] <= nib_sum;
               carry_q          <= c[3];
               if (last_nib) begin
                  cout_q <= c[3];
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CLA_OVF_EN
   logic ovf_q;

   // Carry into the MSB (C2) xor carry out of the MSB (C3) of the top nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_nib) begin
         ovf_q <= c[3] ^ c[2];
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Testbench for cla_nibble_seq_adder: a 16-bit instance (main function,
// back-pressure, reset mid-operation) and a 4-bit instance (single nibble).
module tb_cla_nibble_seq_adder;

  localparam int W  = 16;
  localparam int N  = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 16-bit DUT ----------------
  logic          in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_ready, out_valid, cout, ovf;
  logic [W-1:0]  sum;

  cla_nibble_seq_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // ---------------- 4-bit DUT ----------------
  logic          in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]    a4 = '0, b4 = '0;
  logic          in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]    sum4;

  cla_nibble_seq_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // ---------------- scoreboard ----------------
  // Entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer addition; overflow from operand/result signs.
  function automatic logic [W+1:0] model16(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv);
    logic [W:0] full;
    logic       o;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    o = 1'b0;
`ifdef CLA_OVF_EN
    o = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
`endif
    return {o, full};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [4:0] full;
    logic       o;
    full = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
    o = 1'b0;
`ifdef CLA_OVF_EN
    o = (av[3] == bv[3]) && (full[3] != av[3]);
`endif
    return {o, full};
  endfunction

  // ---------------- driver tasks ----------------
  // All driving happens at negedge; all sampling happens at negedge.
  task automatic wait_in_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  // Run one 16-bit operation. hold = cycles out_ready stays low in DONE
  // (with in_valid high and fresh operands on the pins).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int hold);
    logic [W+1:0] e;
    logic [W-1:0] held;
    int lat;
    exp_q.push_back(model16(av, bv, cv));
    wait_in_ready("in_ready_idle");
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    // Operands are registered; scramble the pins during RUN.
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("latency", 32'(lat), 32'(N));
    e = exp_q.pop_front();
    check("sum", 32'(sum), 32'(e[W-1:0]));
    check("cout", 32'(cout), 32'(e[W]));
    check("ovf", 32'(ovf), 32'(e[W+1]));
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("out_valid_one_cycle", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("sum_kept", 32'(sum), 32'(held));
  endtask

  task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [5:0] e;
    int lat;
    e = model4(av, bv, cv);
    lat = 0;
    while (!in_ready4 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("w4_in_ready", 32'(in_ready4), 32'd1);
    a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("w4_latency", 32'(lat), 32'd1);
    check("w4_sum", 32'(sum4), 32'(e[3:0]));
    check("w4_cout", 32'(cout4), 32'(e[4]));
    check("w4_ovf", 32'(ovf4), 32'(e[5]));
    out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready4 = 1'b0;
    check("w4_out_valid_drop", 32'(out_valid4), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset values while rst is high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed cases.
    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    // Back-pressure: five cycles with out_ready low, then a new operation.
    run_op(16'hA5A5, 16'h0F0F, 1'b1, 5);
    run_op(16'h0102, 16'h0304, 1'b0, 0);

    // Reset during RUN at k=2: accept, two nibble edges, then reset.
    wait_in_ready("in_ready_pre_abort");
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);           // accept edge
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);           // nibble 0
    @(posedge clk); @(negedge clk);           // nibble 1, now k=2
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 2 * N; i++) begin
        @(posedge clk); @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 0);

    // Randomized operations with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // 4-bit instance.
    run_op4(4'h9, 4'h8, 1'b0);
    run_op4(4'hF, 4'h0, 1'b1);
    run_op4(4'h7, 4'h1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_op4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
